divisor_sequencial: RTL and testbench

Sequential restoring divider, the inverse counterpart of the shift-add `Multiplicador` in the MIPS datapath. It divides a 32-bit unsigned dividend by a 16-bit unsigned divisor and produces a 16-bit quotient and a 16-bit remainder, one quotient bit per clock. It uses the same St/Idle/Done start-and-complete handshake as the multiplier, so the same control FSM can issue MULT and DIV operations interchangeably.

---
 rtl/divisor_sequencial.sv | 151 +++++++++++++++
 tb/tb_divisor_sequencial.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/divisor_sequencial.sv
// -----------------------------------------------------------------------------
// divisor_sequencial
//   Sequential restoring divider: 32-bit unsigned dividend / 16-bit unsigned
//   divisor -> 16-bit quotient and 16-bit remainder, one quotient bit per clock.
//   Uses the St/Idle/Done handshake shared with the shift-add multiplier, so the
//   same control FSM can issue MULT and DIV operations interchangeably.
//
// Ports
//   Clk        in   1  system clock, rising edge
//   Reset      in   1  asynchronous active-high reset
//   St         in   1  start request, sampled only while idle
//   Dividendo  in  32  unsigned dividend, sampled on the start edge
//   Divisor    in  16  unsigned divisor, sampled on the start edge
//   Quociente  out 16  quotient register
//   Resto      out 16  remainder register
//   Idle       out  1  high while waiting for a start
//   Done       out  1  one-cycle completion pulse
//   Overflow   out  1  quotient does not fit in 16 bits (or divisor is zero);
//                      valid with Done, held until the next start
// -----------------------------------------------------------------------------
module divisor_sequencial (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        St,
  input  logic [31:0] Dividendo,
  input  logic [15:0] Divisor,
  output logic [15:0] Quociente,
  output logic [15:0] Resto,
  output logic        Idle,
  output logic        Done,
  output logic        Overflow
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  estado_t     r_estado;
  estado_t     w_prox;

  logic [15:0] r_a;      // partial remainder
  logic [15:0] r_q;      // dividend-low bits shifting out, quotient bits in
  logic [15:0] r_d;      // latched divisor
  logic [3:0]  r_cnt;    // iteration counter
  logic [15:0] r_quoc;
  logic [15:0] r_resto;
  logic        r_ovf;

  // A 16-bit quotient is only possible when the upper dividend half is
  // strictly below the divisor; a zero divisor is caught by the same test.
  logic        w_ovf;
  assign w_ovf = (Divisor == 16'd0) || (Dividendo[31:16] >= Divisor);

  // One restoring step. The compare is 17 bits wide: the bit shifted out of
  // A can make T exceed any 16-bit divisor.
  logic [16:0] w_t;
  logic [16:0] w_sub;
  logic        w_ge;
  logic [15:0] w_a_next;
  logic [15:0] w_q_next;

  assign w_t      = {r_a, r_q[15]};
  assign w_sub    = w_t - {1'b0, r_d};
  assign w_ge     = (w_t >= {1'b0, r_d});
  assign w_a_next = w_ge ? w_sub[15:0] : w_t[15:0];
  assign w_q_next = {r_q[14:0], w_ge};

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    w_prox = r_estado;
    Idle   = 1'b0;
    Done   = 1'b0;
    case (r_estado)
      OCIOSO: begin
        Idle = 1'b1;
        if (St) begin
          w_prox = w_ovf ? FIM : CALC;
        end
      end
      CALC: begin
        if (r_cnt == 4'd15) begin
          w_prox = FIM;
        end
      end
      FIM: begin
        Done   = 1'b1;
        w_prox = OCIOSO;
      end
      default: begin
        w_prox = OCIOSO;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a     <= 16'd0;
      r_q     <= 16'd0;
      r_d     <= 16'd0;
      r_cnt   <= 4'd0;
      r_quoc  <= 16'd0;
      r_resto <= 16'd0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (St) begin
            r_a   <= Dividendo[31:16];
            r_q   <= Dividendo[15:0];
            r_d   <= Divisor;
            r_cnt <= 4'd0;
            r_ovf <= w_ovf;
            if (w_ovf) begin
              r_quoc  <= 16'hFFFF;
              r_resto <= 16'h0000;
            end
          end
        end
        CALC: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 4'd1;
          // Publish the result on the last iteration so it is visible in FIM.
          if (r_cnt == 4'd15) begin
            r_quoc  <= w_q_next;
            r_resto <= w_a_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Quociente = r_quoc;
  assign Resto     = r_resto;
  assign Overflow  = r_ovf;

endmodule

// File: tb/tb_divisor_sequencial.sv
module tb_divisor_sequencial;

  logic        Clk;
  logic        Reset;
  logic        St;
  logic [31:0] Dividendo;
  logic [15:0] Divisor;
  logic [15:0] Quociente;
  logic [15:0] Resto;
  logic        Idle;
  logic        Done;
  logic        Overflow;

  divisor_sequencial dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .St        (St),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Quociente (Quociente),
    .Resto     (Resto),
    .Idle      (Idle),
    .Done      (Done),
    .Overflow  (Overflow)
  );

  initial Clk = 1'b0;
  always #20 Clk = ~Clk;

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    int          lat;
  } vec_t;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Starts one divide and checks latency, Idle, single Done pulse and results.
  task automatic run_vec(input vec_t v);
    int k;
    bit seen;
    n_vec++;
    Dividendo = v.dvd;
    Divisor   = v.dvs;
    St        = 1'b1;
    tick();                       // start edge (edge 0)
    St        = 1'b0;
    Dividendo = ~v.dvd;           // operands are free to change after the start
    Divisor   = ~v.dvs;
    chk("idle_after_start", {31'd0, Idle}, 32'd0);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      if (Done) seen = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    $display("div %08h / %04h : q=%04h r=%04h ovf=%0b latency=%0d", v.dvd, v.dvs,
             Quociente, Resto, Overflow, k + 1);
    if (seen) begin
      chk("latency", k + 1, v.lat);
      chk("quociente", {16'd0, Quociente}, {16'd0, v.q});
      chk("resto", {16'd0, Resto}, {16'd0, v.r});
      chk("overflow", {31'd0, Overflow}, {31'd0, v.ovf});
      tick();
      chk("done_one_cycle", {31'd0, Done}, 32'd0);
      chk("idle_return", {31'd0, Idle}, 32'd1);
      chk("quoc_held", {16'd0, Quociente}, {16'd0, v.q});
    end
  endtask

  vec_t vecs[10];
  int   k2;
  int   done_at[$];
  bit   bad_done;

  initial begin
    vecs[0] = '{32'd126480,     16'd255,     16'd496,    16'd0,    1'b0, 17};
    vecs[1] = '{32'd126485,     16'd496,     16'd255,    16'd5,    1'b0, 17};
    vecs[2] = '{32'd7,          16'd9,       16'd0,      16'd7,    1'b0, 17};
    vecs[3] = '{32'hFFFE0001,   16'hFFFF,    16'hFFFF,   16'h0000, 1'b0, 17};
    vecs[4] = '{32'h12345678,   16'h0000,    16'hFFFF,   16'h0000, 1'b1, 1};
    vecs[5] = '{32'h00100000,   16'h0010,    16'hFFFF,   16'h0000, 1'b1, 1};
    vecs[6] = '{32'h0000FFFF,   16'h0001,    16'hFFFF,   16'h0000, 1'b0, 17};
    vecs[7] = '{32'd0,          16'd5,       16'd0,      16'd0,    1'b0, 17};
    vecs[8] = '{32'hFFFFFFFF,   16'hFFFF,    16'hFFFF,   16'h0000, 1'b1, 1};
    vecs[9] = '{32'h0000FFFF,   16'h8000,    16'h0001,   16'h7FFF, 1'b0, 17};

    Reset     = 1'b1;
    St        = 1'b0;
    Dividendo = 32'd0;
    Divisor   = 16'd0;
    #10;
    chk("rst_quoc", {16'd0, Quociente}, 32'd0);
    chk("rst_resto", {16'd0, Resto}, 32'd0);
    chk("rst_ovf", {31'd0, Overflow}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_idle", {31'd0, Idle}, 32'd1);
    #40;
    Reset = 1'b0;                 // released at 50 ns
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset five cycles into CALC: outputs clear at once, no Done afterwards.
    n_vec++;
    Dividendo = 32'd126480;
    Divisor   = 16'd255;
    St        = 1'b1;
    tick();
    St = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    chk("pre_rst_quoc", {16'd0, Quociente}, {16'd0, 16'h0001});
    Reset = 1'b1;
    #1;
    chk("arst_quoc", {16'd0, Quociente}, 32'd0);
    chk("arst_resto", {16'd0, Resto}, 32'd0);
    chk("arst_idle", {31'd0, Idle}, 32'd1);
    chk("arst_done", {31'd0, Done}, 32'd0);
    tick();
    tick();
    Reset = 1'b0;
    bad_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Done) bad_done = 1'b1;
    end
    chk("no_done_after_abort", {31'd0, bad_done}, 32'd0);
    $display("reset mid-CALC : done_after_abort=%0b", bad_done);
    run_vec('{32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17});

    // St held high: back-to-back divides 18 cycles apart.
    n_vec += 2;
    Dividendo = 32'd1000;
    Divisor   = 16'd10;
    St        = 1'b1;
    tick();                       // edge 0
    k2 = 0;
    while (done_at.size() < 2 && k2 < 60) begin
      if (k2 == 5) begin
        Dividendo = 32'd999;      // mid-CALC change, taken by the next start
        Divisor   = 16'd10;
      end
      if (Done) begin
        done_at.push_back(k2);
        $display("b2b done at edge %0d : q=%0d r=%0d ovf=%0b", k2, Quociente, Resto, Overflow);
        if (done_at.size() == 1) begin
          chk("b2b1_quoc", {16'd0, Quociente}, 32'd100);
          chk("b2b1_resto", {16'd0, Resto}, 32'd0);
        end else begin
          chk("b2b2_quoc", {16'd0, Quociente}, 32'd99);
          chk("b2b2_resto", {16'd0, Resto}, 32'd9);
          St = 1'b0;
        end
      end
      tick();
      k2++;
    end
    chk("b2b_two_pulses", done_at.size(), 2);
    if (done_at.size() == 2) begin
      chk("b2b_first_edge", done_at[0], 16);
      chk("b2b_spacing", done_at[1] - done_at[0], 18);
    end
    St = 1'b0;
    tick();
    tick();
    chk("final_idle", {31'd0, Idle}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
